// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between the UART TX arbiter, its byte sources and the shared
// UART transmitter.
// Handshake: a source holds req_valid/req_data/req_last. A one-cycle req_ready
// pulse means the byte was taken, and the source must advance to its next byte
// or drop req_valid in the following cycle. Toward the transmitter,
// uart_tx_valid is a one-cycle start strobe. uart_tx_data stays stable until
// the transmitter's one-cycle uart_tx_done pulse.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 uart_tx_valid;
  logic [7:0]           uart_tx_data;
  logic                 uart_tx_done;
  logic [2:0]           grant_id;
  logic                 busy;

  // Arbiter side.
  modport master (
    input  req_valid, req_data, req_last, uart_tx_done,
    output req_ready, uart_tx_valid, uart_tx_data, grant_id, busy
  );

  // Environment side: the byte sources plus the transmitter.
  modport slave (
    output req_valid, req_data, req_last, uart_tx_done,
    input  req_ready, uart_tx_valid, uart_tx_data, grant_id, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte
// sources. A grant is held, as a lock, until the last byte of a packet
// completes. The lock is dropped early if the owner stalls for LOCK_TIMEOUT
// idle cycles; a LOCK_TIMEOUT of 0 disables the timeout. All outputs are
// registered.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic              uart_clk,
  input  logic              uart_rst_n,
  uart_tx_arbiter_if.master bus,
  output logic [1:0]        dbg_state,
  output logic              dbg_lock,
  output logic [2:0]        dbg_rr_ptr
);

  localparam bit               TIMEOUT_EN = (LOCK_TIMEOUT > 0);
  localparam int               CNT_W      = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(LOCK_TIMEOUT);
  localparam logic [2:0]       LAST_IDX   = 3'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [2:0]         grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               last_q, last_d;
  logic               lock_q, lock_d;
  logic [2:0]         rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Request vectors are widened to 8 lanes so a 3-bit index always fits.
  logic [7:0]  valid8;
  logic [7:0]  last8;
  logic [63:0] data64;
  logic [2:0]  sel;
  logic        found;
  logic        timeout_hit;
  logic        grant_now;
  logic [2:0]  next_rr;

  assign valid8 = 8'(bus.req_valid);
  assign last8  = 8'(bus.req_last);
  assign data64 = 64'(bus.req_data);

  // Candidate selection: the locked owner only, else first valid from rr_ptr.
  always_comb begin
    int idx;
    idx   = 0;
    sel   = grant_q;
    found = 1'b0;
    if (lock_q) begin
      found = valid8[grant_q];
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = (int'(rr_q) + i) % NUM_REQ;
        if (!found && valid8[idx[2:0]]) begin
          found = 1'b1;
          sel   = idx[2:0];
        end
      end
    end
  end

  // A stalled owner loses its lock once the idle counter reaches the limit.
  assign timeout_hit = TIMEOUT_EN && lock_q && !valid8[grant_q] && (cnt_q == CNT_LIMIT);
  assign grant_now   = (state_q == IDLE) && found && !timeout_hit;
  assign next_rr     = (grant_q == LAST_IDX) ? 3'd0 : grant_q + 3'd1;

  // State and registered-output flops.
  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      state_q    <= IDLE;
      ready_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      grant_q    <= 3'd0;
      busy_q     <= 1'b0;
      last_q     <= 1'b0;
      lock_q     <= 1'b0;
      rr_q       <= 3'd0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      last_q     <= last_d;
      lock_q     <= lock_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state: accept -> one strobe cycle -> wait for the frame to finish.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (grant_now) state_d = ISSUE;
      ISSUE:     state_d = WAIT_DONE;
      WAIT_DONE: if (bus.uart_tx_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, lock, pointer and idle counter.
  always_comb begin
    ready_d    = '0;
    tx_valid_d = 1'b0;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    last_d     = last_q;
    lock_d     = lock_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (timeout_hit) begin
          // Release only; arbitration resumes on the following cycle.
          lock_d = 1'b0;
          rr_d   = next_rr;
          cnt_d  = '0;
        end else if (grant_now) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            ready_d[i] = (sel == 3'(i));
          end
          tx_data_d = data64[{sel, 3'b000} +: 8];
          last_d    = last8[sel];
          grant_d   = sel;
          busy_d    = 1'b1;
          lock_d    = 1'b1;
          cnt_d     = '0;
        end else if (TIMEOUT_EN && lock_q) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ISSUE: tx_valid_d = 1'b1;
      WAIT_DONE: begin
        if (bus.uart_tx_done) begin
          busy_d = 1'b0;
          if (last_q) begin
            lock_d = 1'b0;
            rr_d   = next_rr;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.req_ready     = ready_q;
  assign bus.uart_tx_valid = tx_valid_q;
  assign bus.uart_tx_data  = tx_data_q;
  assign bus.grant_id      = grant_q;
  assign bus.busy          = busy_q;
  assign dbg_state         = state_q;
  assign dbg_lock          = lock_q;
  assign dbg_rr_ptr        = rr_q;

endmodule
